sd_bus_arbiter: RTL and testbench
=================================

SD_BUS_ARBITER -- requirements
Module: sd_bus_arbiter

Interface
REQ-001 SHALL have parameter GAP_CLKS, default 8: number of idle clocks with CSn=1 and MOSI=1 inserted after each released grant.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4096: maximum clocks one grant is held when SD_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port SD_CK  input  1  SPI clock; the single clock; all state updates on its negedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port init_ok  input  1  level from the init engine; high means the card is initialised.
REQ-006 SHALL have ports init_MOSI, init_CSn  input  1 each  init engine bus lines.
REQ-007 SHALL have ports rd_req, rd_done, rd_MOSI, rd_CSn  input  1 each  block-read engine request, one-cycle completion pulse and bus lines.
REQ-008 SHALL have ports wr_req, wr_done, wr_MOSI, wr_CSn  input  1 each  block-write engine equivalents.
REQ-009 SHALL have ports rd_gnt, wr_gnt  output  1 each  registered grants.
REQ-010 SHALL have ports SD_MOSI, SD_CSn  output  1 each  muxed card lines.
REQ-011 SHALL have port busy  output  1  high in any state except READY.
REQ-012 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-013 SHALL implement the states INIT, READY, GNT_RD, GNT_WR and GAP.
REQ-014 INIT: SD_MOSI=init_MOSI and SD_CSn=init_CSn; SHALL move to READY on the first edge with init_ok=1.
REQ-015 READY and GAP: SD_MOSI=1 and SD_CSn=1.
REQ-016 GNT_RD and GNT_WR: SD_MOSI and SD_CSn SHALL be taken combinationally from the granted engine.
REQ-017 In READY, a sampled request SHALL raise its grant on the next negedge; grant latency is 1 clock.
REQ-018 If rd_req and wr_req are sampled together, SHALL grant the engine not served last (round-robin); last_served resets to write, so read wins the first tie.
REQ-019 A grant SHALL stay high until the granted engine's done pulse, regardless of its req level.
REQ-020 A done pulse from a non-granted engine SHALL be ignored.
REQ-021 On the granted engine's done, SHALL drop the grant on that edge, update last_served and enter GAP.
REQ-022 GAP SHALL last exactly GAP_CLKS clocks, then return to READY; requests during GAP stay pending and are not lost.
REQ-023 init_ok=0 in any non-INIT state SHALL force INIT on the next edge, with grants low; an interrupted transaction is not resumed.
REQ-024 The gap counter SHALL be sized clog2(GAP_CLKS+1) and SHALL saturate at 0 with no wrap-around.
REQ-025 rd_gnt and wr_gnt SHALL never be high together.

Reset
REQ-026 While rst_n=0: state=INIT, rd_gnt=0, wr_gnt=0, timeout_err=0, busy=1, counters=0, last_served=write; SD_MOSI and SD_CSn follow init lines.
REQ-027 Reset asserted mid-grant SHALL take effect immediately and asynchronously.

Configuration
REQ-028 With SD_ARB_TIMEOUT_EN defined: a grant counter SHALL count granted clocks; if it reaches TIMEOUT_CLKS-1 without done, SHALL revoke the grant, pulse timeout_err for 1 clock and enter GAP.
REQ-029 Without SD_ARB_TIMEOUT_EN: timeout_err SHALL be tied 0 and no grant counter SHALL exist.

Structure
REQ-030 State encodings and the GAP_CLKS/TIMEOUT_CLKS defaults SHALL live in the shared package sd_pkg, alongside the CMD constants.
REQ-031 Round-robin selection SHALL be a sub-module sd_rr_pick (inputs rd_req, wr_req, last_served; outputs pick_rd, pick_wr).

Verification
REQ-032 Reset, then init_ok=1 after 100 clocks -> READY on the next edge; busy=0; SD_CSn=1.
REQ-033 rd_req=wr_req=1 in READY -> rd_gnt=1 after 1 clock; rd_done -> 8 GAP clocks with CSn=1, then wr_gnt=1; a further tie goes to read.
REQ-034 wr_done pulsed while rd_gnt=1 -> ignored; rd_gnt stays 1; SD_MOSI tracks rd_MOSI.
REQ-035 init_ok dropped during GNT_WR -> wr_gnt=0 next edge, state INIT, SD_CSn=init_CSn.
REQ-036 SD_ARB_TIMEOUT_EN, TIMEOUT_CLKS=16, rd_done never pulsed -> rd_gnt falls after 16 clocks; timeout_err high exactly 1 clock.
REQ-037 rst_n pulsed low mid-GNT_RD -> rd_gnt=0 immediately; INIT; after init_ok, read wins the first tie.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD-card SPI constants, bus arbiter state encoding and parameter defaults.
package sd_pkg;
    typedef enum logic [2:0] {INIT, READY, GNT_RD, GNT_WR, GAP} arb_state_t;
    localparam int unsigned GAP_CLKS_DEF     = 8;
    localparam int unsigned TIMEOUT_CLKS_DEF = 4096;
    localparam logic SRV_RD = 1'b0;
    localparam logic SRV_WR = 1'b1;
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD24  = 6'd24;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;
    localparam logic [5:0] ACMD41 = 6'd41;
endpackage

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: two-way round-robin choice between read and write requests.
module sd_rr_pick
    import sd_pkg::*;
(
    input  logic rd_req,
    input  logic wr_req,
    input  logic last_served,
    output logic pick_rd,
    output logic pick_wr
);
    assign pick_rd = rd_req && (!wr_req || last_served == SRV_WR);
    assign pick_wr = wr_req && (!rd_req || last_served == SRV_RD);
endmodule

// File: rtl/sd_bus_arbiter.sv
// sd_bus_arbiter: shares the SD SPI lines between init, read and write engines (negedge SD_CK).
// Define SD_ARB_TIMEOUT_EN to add a grant watchdog that revokes grants after TIMEOUT_CLKS.
module sd_bus_arbiter
    import sd_pkg::*;
#(
    parameter int unsigned GAP_CLKS     = GAP_CLKS_DEF,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic SD_CK,
    input  logic rst_n,
    input  logic init_ok,
    input  logic init_MOSI,
    input  logic init_CSn,
    input  logic rd_req,
    input  logic rd_done,
    input  logic rd_MOSI,
    input  logic rd_CSn,
    input  logic wr_req,
    input  logic wr_done,
    input  logic wr_MOSI,
    input  logic wr_CSn,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic SD_MOSI,
    output logic SD_CSn,
    output logic busy,
    output logic timeout_err
);
    localparam int GW = $clog2(GAP_CLKS + 1);
    arb_state_t state;
    logic last_served, pick_rd, pick_wr, done, expire;
    logic [GW-1:0] gap_cnt;

    sd_rr_pick u_pick (
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .last_served(last_served),
        .pick_rd    (pick_rd),
        .pick_wr    (pick_wr)
    );

    assign busy    = state != READY;
    assign done    = (state == GNT_RD && rd_done) || (state == GNT_WR && wr_done);
    assign SD_MOSI = state == INIT ? init_MOSI : state == GNT_RD ? rd_MOSI : state == GNT_WR ? wr_MOSI : 1'b1;
    assign SD_CSn  = state == INIT ? init_CSn  : state == GNT_RD ? rd_CSn  : state == GNT_WR ? wr_CSn  : 1'b1;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS);
    logic [TW-1:0] gnt_cnt;
    // Counter sits at zero outside a grant, so each grant starts a fresh budget.
    assign expire = (rd_gnt || wr_gnt) && init_ok && !done && gnt_cnt == TW'(TIMEOUT_CLKS - 1);
    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            gnt_cnt     <= (rd_gnt || wr_gnt) && init_ok && !done && !expire ? gnt_cnt + 1'b1 : '0;
            timeout_err <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            rd_gnt      <= 1'b0;
            wr_gnt      <= 1'b0;
            last_served <= SRV_WR;
            gap_cnt     <= '0;
        end else if (state != INIT && !init_ok) begin
            state   <= INIT;
            rd_gnt  <= 1'b0;
            wr_gnt  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                INIT: if (init_ok) state <= READY;
                READY: begin
                    rd_gnt <= pick_rd;
                    wr_gnt <= pick_wr;
                    state  <= pick_rd ? GNT_RD : pick_wr ? GNT_WR : READY;
                end
                GNT_RD, GNT_WR: if (done || expire) begin
                    rd_gnt      <= 1'b0;
                    wr_gnt      <= 1'b0;
                    last_served <= state == GNT_WR ? SRV_WR : SRV_RD;
                    gap_cnt     <= GW'(GAP_CLKS - 1);
                    state       <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt == '0 ? '0 : gap_cnt - 1'b1;
                    if (gap_cnt == '0) state <= READY;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_bus_arbiter.sv
// tb_sd_bus_arbiter: table-driven directed vectors plus reset/watchdog sequences.
module tb_sd_bus_arbiter;
    localparam int G = 8;
    localparam int T = 16;
    logic SD_CK = 1'b0, rst_n = 1'b0, init_ok = 1'b0;
    logic init_MOSI = 1'b0, init_CSn = 1'b0;
    logic rd_req = 1'b0, rd_done = 1'b0, rd_MOSI = 1'b0, rd_CSn = 1'b0;
    logic wr_req = 1'b0, wr_done = 1'b0, wr_MOSI = 1'b0, wr_CSn = 1'b0;
    logic rd_gnt, wr_gnt, SD_MOSI, SD_CSn, busy, timeout_err;
    int n_vec = 0, n_bad = 0;

    sd_bus_arbiter #(.GAP_CLKS(G), .TIMEOUT_CLKS(T)) dut (
        .SD_CK(SD_CK), .rst_n(rst_n), .init_ok(init_ok),
        .init_MOSI(init_MOSI), .init_CSn(init_CSn),
        .rd_req(rd_req), .rd_done(rd_done), .rd_MOSI(rd_MOSI), .rd_CSn(rd_CSn),
        .wr_req(wr_req), .wr_done(wr_done), .wr_MOSI(wr_MOSI), .wr_CSn(wr_CSn),
        .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .SD_MOSI(SD_MOSI), .SD_CSn(SD_CSn),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 SD_CK = ~SD_CK;

    // ln = {init_MOSI, init_CSn, rd_MOSI, rd_CSn, wr_MOSI, wr_CSn}
    // ex = {rd_gnt, wr_gnt, busy, SD_MOSI, SD_CSn, timeout_err}
    typedef struct packed {
        logic       ok;
        logic [1:0] rq;
        logic [1:0] dn;
        logic [5:0] ln;
        logic [5:0] ex;
    } vec_t;

    localparam logic [5:0] L0    = 6'b00_10_00;
    localparam logic [5:0] LM0   = 6'b00_00_00;
    localparam logic [5:0] LW1   = 6'b00_10_11;
    localparam logic [5:0] RDY   = 6'b00_0_11_0;
    localparam logic [5:0] GAPX  = 6'b00_1_11_0;
    localparam logic [5:0] RDG   = 6'b10_1_10_0;
    localparam logic [5:0] RDG0  = 6'b10_1_00_0;
    localparam logic [5:0] WRG   = 6'b01_1_00_0;
    localparam logic [5:0] WRG1  = 6'b01_1_11_0;
    localparam logic [5:0] INITX = 6'b00_1_00_0;
    localparam logic [5:0] TOX   = 6'b00_1_11_1;

    vec_t tbl[$];

    function automatic vec_t mk(logic ok, logic [1:0] rq, logic [1:0] dn, logic [5:0] ln, logic [5:0] ex);
        mk = {ok, rq, dn, ln, ex};
    endfunction

    task automatic check(input string nm, input logic [5:0] ex);
        logic [5:0] got;
        got = {rd_gnt, wr_gnt, busy, SD_MOSI, SD_CSn, timeout_err};
        n_vec++;
        if (got !== ex) begin
            n_bad++;
            $display("FAIL %s @%0t: got {rd,wr,busy,mosi,csn,to}=%b want %b", nm, $time, got, ex);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        {init_ok, rd_req, wr_req, rd_done, wr_done} = {v.ok, v.rq, v.dn};
        {init_MOSI, init_CSn, rd_MOSI, rd_CSn, wr_MOSI, wr_CSn} = v.ln;
        @(negedge SD_CK);
        @(posedge SD_CK);
        check(nm, v.ex);
    endtask

    task automatic push_gap(input logic [1:0] rq);
        for (int i = 0; i < G - 1; i++) tbl.push_back(mk(1'b1, rq, 2'b00, L0, GAPX));
        tbl.push_back(mk(1'b1, rq, 2'b00, L0, RDY));
    endtask

    task automatic run_gap(input string nm);
        for (int i = 0; i < G - 1; i++) apply(mk(1'b1, 2'b00, 2'b00, L0, GAPX), nm);
        apply(mk(1'b1, 2'b00, 2'b00, L0, RDY), {nm, "_ready"});
    endtask

    initial begin
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, L0, RDY));
        tbl.push_back(mk(1'b1, 2'b11, 2'b00, L0, RDG));
        tbl.push_back(mk(1'b1, 2'b11, 2'b01, LM0, RDG0));
        tbl.push_back(mk(1'b1, 2'b11, 2'b00, L0, RDG));
        tbl.push_back(mk(1'b1, 2'b01, 2'b10, L0, GAPX));
        push_gap(2'b11);
        tbl.push_back(mk(1'b1, 2'b11, 2'b00, L0, WRG));
        tbl.push_back(mk(1'b1, 2'b11, 2'b01, L0, GAPX));
        push_gap(2'b11);
        tbl.push_back(mk(1'b1, 2'b11, 2'b00, L0, RDG));
        tbl.push_back(mk(1'b1, 2'b00, 2'b10, L0, GAPX));
        push_gap(2'b00);
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, LW1, WRG1));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, LW1, WRG1));
        tbl.push_back(mk(1'b0, 2'b01, 2'b00, LW1, INITX));
        tbl.push_back(mk(1'b0, 2'b01, 2'b00, LW1, INITX));
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, L0, RDY));

        @(posedge SD_CK);
        check("reset_state", INITX);
        {init_MOSI, init_CSn} = 2'b11;
        #1 check("reset_init_lines", GAPX);
        {init_MOSI, init_CSn} = 2'b00;
        @(posedge SD_CK);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) apply(mk(1'b0, 2'b00, 2'b00, L0, INITX), "init_wait");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef SD_ARB_TIMEOUT_EN
        apply(mk(1'b1, 2'b10, 2'b00, L0, RDG), "to_grant");
        for (int i = 1; i < T; i++) apply(mk(1'b1, 2'b00, 2'b00, L0, RDG), "to_hold");
        apply(mk(1'b1, 2'b00, 2'b00, L0, TOX), "to_fire");
        apply(mk(1'b1, 2'b00, 2'b00, L0, GAPX), "to_pulse_end");
        for (int i = 0; i < G - 2; i++) apply(mk(1'b1, 2'b00, 2'b00, L0, GAPX), "to_gap");
        apply(mk(1'b1, 2'b00, 2'b00, L0, RDY), "to_ready");
`endif

        apply(mk(1'b1, 2'b10, 2'b00, L0, RDG), "pre_rst_grant");
        apply(mk(1'b1, 2'b00, 2'b10, L0, GAPX), "pre_rst_done");
        run_gap("pre_rst_gap");
        apply(mk(1'b1, 2'b10, 2'b00, L0, RDG), "pre_rst_grant2");
        #2 rst_n = 1'b0;
        #1 check("rst_async", INITX);
        @(posedge SD_CK);
        rst_n = 1'b1;
        apply(mk(1'b1, 2'b00, 2'b00, L0, RDY), "rst_init_ok");
        apply(mk(1'b1, 2'b11, 2'b00, L0, RDG), "rr_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
